// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and limits for the shared data-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam int CORES_MIN     = 2;
    localparam int CORES_MAX     = 8;
    localparam int LAT_MIN       = 1;
    localparam int LAT_MAX       = 4;
    localparam int CNT_W         = 3;
    localparam int NUM_CORES_DEF = 4;
    localparam int IDX_W_DEF     = $clog2(NUM_CORES_DEF);

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - first set request at or after a pointer, wrapping
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int N     = NUM_CORES_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);
    localparam int SUM_W = IDX_W + 1;

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [SUM_W-1:0] w_sum;

    // Rotate so bit 0 is the request at the pointer; the lowest set bit is the winner.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_valid = |i_req;
    assign o_idx   = (w_sum >= SUM_W'(N)) ? IDX_W'(w_sum - SUM_W'(N)) : w_sum[IDX_W-1:0];

endmodule

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - round-robin sharing of one fixed-latency data-memory port among cores
module shared_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_we,
    input  logic [NUM_CORES-1:0]          core_half,
    input  logic [NUM_CORES-1:0]          core_byte,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_stall,
    output logic [NUM_CORES-1:0]          core_done,
    output logic [DATA_W-1:0]             core_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic                          mem_half,
    output logic                          mem_byte,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);
    localparam int IDX_W = idx_width(NUM_CORES);

    if (MEM_LAT < LAT_MIN || MEM_LAT > LAT_MAX) begin : g_bad_lat
        $error("shared_mem_arbiter: MEM_LAT must lie within 1..4");
    end
    if (NUM_CORES < CORES_MIN || NUM_CORES > CORES_MAX) begin : g_bad_cores
        $error("shared_mem_arbiter: NUM_CORES must lie within 2..8");
    end

    arb_state_t           r_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_CORES-1:0] r_done;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_mem_en;
    logic                 r_mem_we;
    logic                 r_mem_half;
    logic                 r_mem_byte;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;

    logic [ADDR_W-1:0]    w_addr  [NUM_CORES];
    logic [DATA_W-1:0]    w_wdata [NUM_CORES];
    logic                 w_valid;
    logic [IDX_W-1:0]     w_idx;
    logic [IDX_W-1:0]     w_next_ptr;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign w_addr[g]  = core_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = core_wdata[g*DATA_W +: DATA_W];
    end

    rr_priority_picker #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (core_req),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    assign w_next_ptr = (w_idx == IDX_W'(NUM_CORES - 1)) ? '0 : w_idx + IDX_W'(1);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_half  <= 1'b0;
            r_mem_byte  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_done   <= '0;
            r_mem_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_owner     <= w_idx;
                        r_rr_ptr    <= w_next_ptr;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= core_we[w_idx];
                        r_mem_half  <= core_half[w_idx];
                        r_mem_byte  <= core_byte[w_idx];
                        r_mem_addr  <= w_addr[w_idx];
                        r_mem_wdata <= w_wdata[w_idx];
                        r_cnt       <= '0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The cycle the counter reaches MEM_LAT is the one where mem_rdata is valid.
                    if (r_cnt == CNT_W'(MEM_LAT)) begin
                        r_rdata <= mem_rdata;
                        r_done  <= NUM_CORES'(1) << r_owner;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_stall = core_req & ~r_done;
    assign core_done  = r_done;
    assign core_rdata = r_rdata;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_half   = r_mem_half;
    assign mem_byte   = r_mem_byte;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule
